// File: rtl/cnn_div_seq_22s_13ns.sv
// Sequential radix-2 restoring divider: signed dividend by unsigned divisor,
// truncated quotient with a remainder that carries the dividend's sign.
module cnn_div_seq_22s_13ns #(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = 22,
  parameter int DIVISOR_W  = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  rem_mag;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;

  logic                  accept;
  logic                  last_step;
  logic [DIVIDEND_W-1:0] dividend_abs;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_step;
  logic [DIVIDEND_W-1:0] dvd_step;

  assign accept       = in_valid && in_ready;
  assign last_step    = (state == CALC) && (cnt == CNT_LAST);
  // Unsigned magnitude, so the most negative dividend still fits.
  assign dividend_abs = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;

  // dvd_mag shifts dividend bits out of the top and quotient bits in at the bottom.
  assign shifted  = {rem_mag, dvd_mag[DIVIDEND_W-1]};
  assign ge       = shifted >= {1'b0, dvs};
  assign rem_step = ge ? DIVISOR_W'(shifted - {1'b0, dvs}) : shifted[DIVISOR_W-1:0];
  assign dvd_step = {dvd_mag[DIVIDEND_W-2:0], ge};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd_mag     <= '0;
      dvs         <= '0;
      rem_mag     <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd_mag <= dividend_abs;
        neg     <= dividend[DIVIDEND_W-1];
        dvs     <= divisor;
        rem_mag <= '0;
        cnt     <= '0;
        if (divisor == '0) begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        dvd_mag <= dvd_step;
        rem_mag <= rem_step;
        cnt     <= cnt + 1'b1;
        if (last_step) begin
          quotient    <= neg ? -dvd_step : dvd_step;
          remainder   <= neg ? -{1'b0, rem_step} : {1'b0, rem_step};
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cnn_div_seq_22s_13ns.md
Name: cnn_div_seq_22s_13ns

Overview:
- Sequential radix-2 signed-by-unsigned divider. It is the inverse of the 13-bit unsigned × 9-bit signed → 22-bit signed product multiplier.
- Takes a 22-bit signed dividend (e.g. an accumulated product) and a 13-bit unsigned divisor (e.g. a scale factor). Returns the truncated quotient and remainder.
- Used in the CNN datapath for rescaling and averaging.
- Valid/ready handshake on both sides; one division in flight at a time.

Parameters:
- ID, 1, instance identifier; no functional effect.
- DIVIDEND_W, 22, dividend and quotient width (signed).
- DIVISOR_W, 13, divisor width (unsigned).

Ports:
- ap_clk  in  1  clock; all state changes on its rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  dividend/divisor present.
- in_ready  out  1  block can accept an operand pair.
- dividend  in  DIVIDEND_W  signed dividend.
- divisor  in  DIVISOR_W  unsigned divisor.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  DIVIDEND_W  signed quotient, truncated toward zero.
- remainder  out  DIVISOR_W+1  signed remainder; same sign as the dividend, or zero.
- div_by_zero  out  1  result was produced with divisor == 0.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - quotient = 0, remainder = 0, div_by_zero = 0
  - iteration counter = 0
- Reset is honoured in any state. A division in progress is discarded; no partial result is ever presented.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on an edge where in_valid & in_ready are both high.
  - On accept, latch |dividend| (DIVIDEND_W bits, unsigned, so -2^21 is representable), the dividend sign, and the divisor. Clear the partial remainder and set cnt = 0.
  - If divisor != 0: go to CALC.
  - If divisor == 0: go to DONE with quotient = 0, remainder = 0, div_by_zero = 1.
- CALC:
  - in_ready = 0.
  - One restoring step per cycle, MSB first: shift the partial remainder left with the next dividend bit. If the result is ≥ divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
  - cnt increments each cycle. On the edge where cnt == DIVIDEND_W-1, the final step completes and the block moves to DONE.
  - On that same edge the output registers load the sign-corrected results:
    - quotient = negative if the dividend was negative, else positive magnitude.
    - remainder = negative if the dividend was negative, else positive magnitude.
    - div_by_zero = 0.
- DONE:
  - out_valid = 1; outputs are held stable while out_ready = 0.
  - On an edge with out_ready = 1, go to IDLE with out_valid = 0.
  - Outputs keep their last values in IDLE; they are don't-care while out_valid = 0.
- Latency, counted from the accept edge:
  - Normal division: out_valid rises after DIVIDEND_W (22) edges.
  - Divide-by-zero: out_valid rises after 1 edge.
- Minimum initiation interval: 24 cycles (accept, 22 CALC cycles, 1 DONE cycle with out_ready held high).
- Input ignore rule: in_valid, dividend and divisor are ignored outside IDLE. Inputs are sampled only on the accept edge.
- Arithmetic invariant:
  - dividend == quotient*divisor + remainder, and |remainder| < divisor.
  - No overflow is possible: |quotient| ≤ 2^21, which fits DIVIDEND_W signed for every dividend.
- Simultaneous events: out_ready arriving in the same cycle that DONE is entered has no effect. The handshake completes only on an edge where the state is already DONE.

Test Plan:
- Reset → in_ready=1, out_valid=0, all outputs 0. Then dividend=1000, divisor=7 → out_valid exactly 22 edges after accept; quotient=142, remainder=6, div_by_zero=0.
- Sign handling:
  - dividend=-1000, divisor=7 → quotient=-142, remainder=-6.
  - dividend=-7, divisor=1000 → quotient=0, remainder=-7.
- Inverse-of-multiply and extremes:
  - dividend=-2096896 (8191×-256), divisor=8191 → quotient=-256, remainder=0.
  - dividend=-2097152, divisor=1 → quotient=-2097152, remainder=0.
- Divide-by-zero: dividend=5, divisor=0 → out_valid after 1 edge; div_by_zero=1, quotient=0, remainder=0. The next division (20/3) returns div_by_zero=0, quotient=6, remainder=2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0 throughout. Changing in_valid/dividend during CALC and DONE does not alter the result.
- Reset mid-op: assert ap_rst asynchronously at cnt=10 → outputs clear immediately, with no out_valid pulse. A subsequent 99/9 yields quotient 11, remainder 0. Random regression of 10k operand pairs against a reference model with truncation semantics.
